// File: rtl/tlc_pkg.sv
// Shared definitions for the intersection phase scheduler and the lamp decoder:
// phase and sub-state codes, the direction encoding, and the duration lookup.
package tlc_pkg;

  // Phase codes. The numeric values are visible on the phase output.
  typedef enum logic [2:0] {
    PH_NS_GRN = 3'd0,
    PH_NS_YEL = 3'd1,
    PH_AR_A   = 3'd2,
    PH_EW_GRN = 3'd3,
    PH_EW_YEL = 3'd4,
    PH_AR_B   = 3'd5,
    PH_PED    = 3'd6,
    PH_INIT   = 3'd7
  } phase_t;

  // Each timed phase has a one-cycle LOAD (timer strobe) followed by WAIT.
  typedef enum logic {
    SUB_LOAD = 1'b0,
    SUB_WAIT = 1'b1
  } sub_t;

  // Direction served after a pedestrian phase.
  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  // Default durations in timer ticks.
  localparam int T_GREEN_DEF  = 30;
  localparam int T_YEL_DEF    = 5;
  localparam int T_ALLRED_DEF = 2;
  localparam int T_WALK_DEF   = 10;

  // Duration in ticks of a phase. INIT is never timed; it returns 1 so the
  // derived load value is zero.
  function automatic int phase_duration(
    input phase_t ph,
    input int     t_green,
    input int     t_yel,
    input int     t_allred,
    input int     t_walk
  );
    int dur;
    dur = 1;
    case (ph)
      PH_NS_GRN, PH_EW_GRN: dur = t_green;
      PH_NS_YEL, PH_EW_YEL: dur = t_yel;
      PH_AR_A, PH_AR_B:     dur = t_allred;
      PH_PED:               dur = t_walk;
      default:              dur = 1;
    endcase
    return dur;
  endfunction

  // True when a phase is one of the two all-red clearance intervals.
  function automatic logic is_all_red(input phase_t ph);
    return (ph == PH_AR_A) || (ph == PH_AR_B);
  endfunction

endpackage

// File: rtl/tlc_lamp_decode.sv
// Purely combinational phase -> lamp decoder. Lamps depend on the phase code
// alone, so they do not change between the LOAD and WAIT halves of a phase.
import tlc_pkg::*;

module tlc_lamp_decode (
  input  logic [2:0] i_phase,
  output logic       o_ns_red,
  output logic       o_ns_yel,
  output logic       o_ns_grn,
  output logic       o_ew_red,
  output logic       o_ew_yel,
  output logic       o_ew_grn,
  output logic       o_walk
);

  phase_t w_phase;

  assign w_phase = phase_t'(i_phase);

  // Active direction shows green/yellow, the other shows red; every
  // clearance, walk and init phase shows both reds.
  always_comb begin
    o_ns_red = 1'b1;
    o_ns_yel = 1'b0;
    o_ns_grn = 1'b0;
    o_ew_red = 1'b1;
    o_ew_yel = 1'b0;
    o_ew_grn = 1'b0;
    o_walk   = 1'b0;
    case (w_phase)
      PH_NS_GRN: begin
        o_ns_red = 1'b0;
        o_ns_grn = 1'b1;
      end
      PH_NS_YEL: begin
        o_ns_red = 1'b0;
        o_ns_yel = 1'b1;
      end
      PH_EW_GRN: begin
        o_ew_red = 1'b0;
        o_ew_grn = 1'b1;
      end
      PH_EW_YEL: begin
        o_ew_red = 1'b0;
        o_ew_yel = 1'b1;
      end
      PH_PED: begin
        o_walk = 1'b1;
      end
      default: begin
        o_ns_red = 1'b1;
        o_ew_red = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase sequencer driving a shared down-counter timer.
//
//   state          | meaning
//   ---------------+---------------------------------------------------------
//   INIT           | one cycle after reset, both reds, then AR_B/LOAD
//   <phase>/LOAD   | single cycle: strobe dp_load with duration-1
//   <phase>/WAIT   | hold until count_done, then LOAD of the next phase
//   NS_GRN,NS_YEL  | north-south green / yellow
//   AR_A           | clearance after NS; may go to PED, EW_GRN or NS_GRN
//   EW_GRN,EW_YEL  | east-west green / yellow
//   AR_B           | clearance after EW; may go to PED or NS_GRN
//   PED            | walk lamp; then green of next_dir without extra all-red
import tlc_pkg::*;

module intersection_phase_scheduler #(
  parameter int CNT_W      = 5,
  parameter int T_GREEN    = T_GREEN_DEF,
  parameter int T_YEL      = T_YEL_DEF,
  parameter int T_ALLRED   = T_ALLRED_DEF,
  parameter int T_WALK     = T_WALK_DEF,
  parameter int EW_SKIP_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_done,
  input  logic             ew_car,
  input  logic             ped_req,
  output logic             dp_load,
  output logic [CNT_W-1:0] dp_value,
  output logic             ns_red,
  output logic             ns_yel,
  output logic             ns_grn,
  output logic             ew_red,
  output logic             ew_yel,
  output logic             ew_grn,
  output logic             walk,
  output logic             ped_ack,
  output logic [2:0]       phase
);

  phase_t           r_phase;
  sub_t             r_sub;
  dir_t             r_next_dir;
  logic             r_ped_pending;

  phase_t           w_phase_nxt;
  sub_t             w_sub_nxt;
  dir_t             w_dir_nxt;
  logic             w_ped_pending_nxt;
  logic             w_enter_ped;
  logic             w_in_load;
  logic             w_phase_done;
  int               w_dur;
  logic [CNT_W-1:0] w_load_val;

  // LOAD is a timed phase's strobe cycle; INIT never loads the timer.
  assign w_in_load    = (r_sub == SUB_LOAD) && (r_phase != PH_INIT);
  assign w_phase_done = (r_sub == SUB_WAIT) && (r_phase != PH_INIT) && count_done;

  // Timer load value for the current phase, duration minus one.
  always_comb begin
    w_dur      = phase_duration(r_phase, T_GREEN, T_YEL, T_ALLRED, T_WALK);
    w_load_val = CNT_W'(w_dur - 1);
  end

  // Next phase, sub-state and post-walk direction.
  always_comb begin
    w_phase_nxt = r_phase;
    w_sub_nxt   = r_sub;
    w_dir_nxt   = r_next_dir;
    w_enter_ped = 1'b0;

    if (r_phase == PH_INIT) begin
      w_phase_nxt = PH_AR_B;
      w_sub_nxt   = SUB_LOAD;
    end else if (r_sub == SUB_LOAD) begin
      w_sub_nxt = SUB_WAIT;
    end else if (w_phase_done) begin
      w_sub_nxt = SUB_LOAD;
      case (r_phase)
        PH_NS_GRN: w_phase_nxt = PH_NS_YEL;
        PH_NS_YEL: w_phase_nxt = PH_AR_A;
        PH_AR_A: begin
          if (r_ped_pending) begin
            w_phase_nxt = PH_PED;
            w_dir_nxt   = DIR_EW;
            w_enter_ped = 1'b1;
          end else if ((EW_SKIP_EN != 0) && !ew_car) begin
            w_phase_nxt = PH_NS_GRN;
          end else begin
            w_phase_nxt = PH_EW_GRN;
          end
        end
        PH_EW_GRN: w_phase_nxt = PH_EW_YEL;
        PH_EW_YEL: w_phase_nxt = PH_AR_B;
        PH_AR_B: begin
          if (r_ped_pending) begin
            w_phase_nxt = PH_PED;
            w_dir_nxt   = DIR_NS;
            w_enter_ped = 1'b1;
          end else begin
            w_phase_nxt = PH_NS_GRN;
          end
        end
        PH_PED: w_phase_nxt = (r_next_dir == DIR_EW) ? PH_EW_GRN : PH_NS_GRN;
        default: begin
          w_phase_nxt = PH_AR_B;
        end
      endcase
    end
  end

  // Pedestrian latch: clearing on PED entry wins over a simultaneous request,
  // and requests seen while walking are dropped so only one walk is served.
  always_comb begin
    w_ped_pending_nxt = r_ped_pending;
    if (w_enter_ped) begin
      w_ped_pending_nxt = 1'b0;
    end else if (r_phase == PH_PED) begin
      w_ped_pending_nxt = 1'b0;
    end else if (ped_req) begin
      w_ped_pending_nxt = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase       <= PH_INIT;
      r_sub         <= SUB_WAIT;
      r_next_dir    <= DIR_NS;
      r_ped_pending <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_sub         <= w_sub_nxt;
      r_next_dir    <= w_dir_nxt;
      r_ped_pending <= w_ped_pending_nxt;
    end
  end

  // Moore outputs decoded from the registered state.
  assign dp_load  = w_in_load;
  assign dp_value = w_in_load ? w_load_val : '0;
  assign ped_ack  = (r_phase == PH_PED) && (r_sub == SUB_LOAD);
  assign phase    = r_phase;

  tlc_lamp_decode u_lamp_decode (
    .i_phase  (r_phase),
    .o_ns_red (ns_red),
    .o_ns_yel (ns_yel),
    .o_ns_grn (ns_grn),
    .o_ew_red (ew_red),
    .o_ew_yel (ew_yel),
    .o_ew_grn (ew_grn),
    .o_walk   (walk)
  );

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler: expected timer loads are
// queued as stimulus is driven and compared whenever the DUT strobes dp_load.
module tb_intersection_phase_scheduler;

  logic       clk;
  logic       reset;
  logic       count_done;
  logic       ew_car;
  logic       ped_req;
  logic       dp_load;
  logic [4:0] dp_value;
  logic       ns_red, ns_yel, ns_grn;
  logic       ew_red, ew_yel, ew_grn;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;
  logic [6:0] lamps;

  typedef struct {
    logic [2:0] ph;
    logic [4:0] val;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   checks;
  int   errors;
  int   ack_cnt;
  int   ack0;
  logic prev_load;
  logic [2:0] s5 [4];

  intersection_phase_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .count_done (count_done),
    .ew_car     (ew_car),
    .ped_req    (ped_req),
    .dp_load    (dp_load),
    .dp_value   (dp_value),
    .ns_red     (ns_red),
    .ns_yel     (ns_yel),
    .ns_grn     (ns_grn),
    .ew_red     (ew_red),
    .ew_yel     (ew_yel),
    .ew_grn     (ew_grn),
    .walk       (walk),
    .ped_ack    (ped_ack),
    .phase      (phase)
  );

  assign lamps = {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, walk};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] load_for(input logic [2:0] ph);
    case (ph)
      3'd0, 3'd3: return 5'd29;
      3'd1, 3'd4: return 5'd4;
      3'd2, 3'd5: return 5'd1;
      3'd6:       return 5'd9;
      default:    return 5'd0;
    endcase
  endfunction

  // {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, walk}
  function automatic logic [6:0] lamps_for(input logic [2:0] ph);
    case (ph)
      3'd0:    return 7'b0011000;
      3'd1:    return 7'b0101000;
      3'd3:    return 7'b1000010;
      3'd4:    return 7'b1000100;
      3'd6:    return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction

  task automatic push(input logic [2:0] ph);
    exp_t e;
    e.ph  = ph;
    e.val = load_for(ph);
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the LOAD cycle of ph; leaves the bench in the next LOAD cycle.
  task automatic run_phase(input logic [2:0] ph, input int nwait);
    check("load_phase", 32'(phase), 32'(ph));
    check("load_strobe", 32'(dp_load), 32'd1);
    check("load_lamps", 32'(lamps), 32'(lamps_for(ph)));
    step();
    for (int i = 0; i < nwait; i++) begin
      check("wait_hold", 32'(dp_load), 32'd0);
      step();
    end
    check("wait_phase", 32'(phase), 32'(ph));
    check("wait_value", 32'(dp_value), 32'd0);
    check("wait_lamps", 32'(lamps), 32'(lamps_for(ph)));
    count_done = 1'b1;
    step();
    count_done = 1'b0;
    check("done_latency", 32'(dp_load), 32'd1);
  endtask

  // Scoreboard side: every timer strobe must match the next queued load.
  always @(posedge clk) begin
    #1;
    if (dp_load === 1'b1) begin
      check("load_one_cycle", 32'(prev_load), 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL extra_load: observed load in phase %0d, expected none", phase);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_phase", 32'(phase), 32'(sb_e.ph));
        check("sb_value", 32'(dp_value), 32'(sb_e.val));
      end
    end
    if (ped_ack === 1'b1) ack_cnt++;
    prev_load = dp_load;
  end

  initial begin
    checks     = 0;
    errors     = 0;
    ack_cnt    = 0;
    prev_load  = 1'b0;
    reset      = 1'b1;
    count_done = 1'b0;
    ew_car     = 1'b1;
    ped_req    = 1'b0;
    s5[0] = 3'd1; s5[1] = 3'd2; s5[2] = 3'd3; s5[3] = 3'd4;

    // Reset state
    step();
    step();
    check("rst_phase", 32'(phase), 32'd7);
    check("rst_lamps", 32'(lamps), 32'(7'b1001000));
    check("rst_load", 32'(dp_load), 32'd0);
    check("rst_value", 32'(dp_value), 32'd0);
    check("rst_ack", 32'(ped_ack), 32'd0);
    reset = 1'b0;
    #1;
    check("init_phase", 32'(phase), 32'd7);
    check("init_load", 32'(dp_load), 32'd0);

    // 1: basic order with ew_car=1
    push(3'd5); push(3'd0); push(3'd1); push(3'd2);
    push(3'd3); push(3'd4); push(3'd5); push(3'd0);
    step();
    run_phase(3'd5, 0);
    run_phase(3'd0, 2);
    run_phase(3'd1, 1);
    run_phase(3'd2, 0);
    run_phase(3'd3, 3);
    run_phase(3'd4, 0);
    run_phase(3'd5, 1);

    // 2: pedestrian request during NS_GRN/WAIT -> PED after AR_A -> EW_GRN
    push(3'd1); push(3'd2); push(3'd6); push(3'd3);
    ack0 = ack_cnt;
    check("ns_load", 32'(phase), 32'd0);
    step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    count_done = 1'b1;
    step();
    count_done = 1'b0;
    run_phase(3'd1, 0);
    run_phase(3'd2, 0);
    check("ped_phase", 32'(phase), 32'd6);
    check("ped_value", 32'(dp_value), 32'd9);
    check("ped_lamps", 32'(lamps), 32'(7'b1001001));
    check("ped_ack_hi", 32'(ped_ack), 32'd1);
    step();
    check("ped_ack_lo", 32'(ped_ack), 32'd0);
    check("ped_walk", 32'(walk), 32'd1);
    count_done = 1'b1;
    step();
    count_done = 1'b0;
    check("after_ped", 32'(phase), 32'd3);
    check("ack_count_s2", 32'(ack_cnt - ack0), 32'd1);

    // 3: east-west skip with no car, then car present only at AR_A exit
    push(3'd4); push(3'd5); push(3'd0); push(3'd1); push(3'd2);
    push(3'd0); push(3'd1); push(3'd2); push(3'd3);
    run_phase(3'd3, 0);
    run_phase(3'd4, 0);
    run_phase(3'd5, 0);
    run_phase(3'd0, 0);
    run_phase(3'd1, 0);
    ew_car = 1'b0;
    run_phase(3'd2, 1);
    ew_car = 1'b1;
    check("skip_ew", 32'(phase), 32'd0);
    run_phase(3'd0, 0);
    run_phase(3'd1, 0);
    ew_car = 1'b0;
    step();
    step();
    ew_car = 1'b1;
    count_done = 1'b1;
    step();
    count_done = 1'b0;
    check("no_skip_ew", 32'(phase), 32'd3);

    // 4: ped_req held through PED -> one walk, one ack
    push(3'd4); push(3'd5); push(3'd6); push(3'd0); push(3'd1);
    push(3'd2); push(3'd3); push(3'd4); push(3'd5); push(3'd0);
    run_phase(3'd3, 0);
    run_phase(3'd4, 0);
    ped_req = 1'b1;
    ack0 = ack_cnt;
    run_phase(3'd5, 0);
    check("ped2_phase", 32'(phase), 32'd6);
    check("ped2_ack", 32'(ped_ack), 32'd1);
    step();
    step();
    ped_req = 1'b0;
    step();
    check("ped2_walk", 32'(walk), 32'd1);
    count_done = 1'b1;
    step();
    count_done = 1'b0;
    check("ped2_to_ns", 32'(phase), 32'd0);
    check("ack_count_s4", 32'(ack_cnt - ack0), 32'd1);
    run_phase(3'd0, 0);
    run_phase(3'd1, 0);
    run_phase(3'd2, 0);
    check("no_second_walk_a", 32'(phase), 32'd3);
    run_phase(3'd3, 0);
    run_phase(3'd4, 0);
    run_phase(3'd5, 0);
    check("no_second_walk_b", 32'(phase), 32'd0);
    check("ack_count_s4b", 32'(ack_cnt - ack0), 32'd1);

    // 5: count_done held high -> two cycles per phase
    push(3'd1); push(3'd2); push(3'd3); push(3'd4);
    count_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("hold_wait", 32'(dp_load), 32'd0);
      step();
      check("hold_load", 32'(dp_load), 32'd1);
      check("hold_phase", 32'(phase), 32'(s5[k]));
    end
    step();
    count_done = 1'b0;
    check("hold_ew_yel_wait", 32'(phase), 32'd4);

    // 6: reset mid EW_YEL/WAIT with a pending walk
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("pre_rst_phase", 32'(phase), 32'd4);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_phase", 32'(phase), 32'd7);
    check("mid_rst_lamps", 32'(lamps), 32'(7'b1001000));
    check("mid_rst_load", 32'(dp_load), 32'd0);
    step();
    reset = 1'b0;
    push(3'd5); push(3'd0); push(3'd1); push(3'd2); push(3'd3);
    step();
    run_phase(3'd5, 0);
    check("restart_ns", 32'(phase), 32'd0);
    run_phase(3'd0, 0);
    run_phase(3'd1, 0);
    run_phase(3'd2, 0);
    check("pending_cleared", 32'(phase), 32'd3);

    step();
    step();
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
